// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: byte/instruction
// widths and the loader state encoding, also used by control_unit and
// instruction_memory.
package im_loader_pkg;

  localparam int BYTE_W   = 8;
  localparam int INSTR_W  = 15;
  localparam int OPCODE_W = 7;

  typedef enum logic [2:0] {
    ST_COUNT  = 3'd0,
    ST_HI     = 3'd1,
    ST_LO     = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic state_accepts(state_e s);
    return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/im_loader.sv
// Instruction-memory loader. Takes a byte stream framed as
//   N, {hi, lo} x N [, checksum]
// and writes each 15-bit word {hi[6:0], lo} to IM addresses 0..N-1, holding
// the CPU until the frame completes successfully.
// Build option: IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (CHECK state and an 8-bit accumulator); without it no checksum logic exists.
//
// Stream handshake: a byte moves when in_valid & in_ready are both high on a
// rising clock edge; the source must hold in_data stable while in_valid is
// high and in_ready is low. in_ready is a pure decode of the state (and is
// forced low while reset is asserted).
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                im_we,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [INSTR_W-1:0]  im_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output state_e              dbg_state
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BYTE_W-1:0]    words_left_q, words_left_d;
  logic [OPCODE_W-1:0]  hi_q, hi_d;
  logic                 im_we_q, im_we_d;
  logic [INSTR_W-1:0]   im_wdata_q, im_wdata_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]    xsum_q, xsum_d;
`endif

  logic xfer;

  // Ready is a state decode; suppressed while reset is held.
  assign in_ready = ~reset & state_accepts(state_q);
  assign xfer     = in_valid & in_ready;

  // Next-state and next-output computation for the load sequence.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    hi_d         = hi_q;
    im_we_d      = 1'b0;
    im_wdata_d   = im_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;
`ifdef IM_LOADER_CHECKSUM_EN
    xsum_d       = xsum_q;
`endif
    case (state_q)
      ST_COUNT: begin
        if (xfer) begin
          words_left_d = in_data;
`ifdef IM_LOADER_CHECKSUM_EN
          xsum_d       = in_data;
          state_d      = (in_data == '0) ? ST_CHECK : ST_HI;
`else
          state_d      = (in_data == '0) ? ST_FINISH : ST_HI;
`endif
        end
      end
      ST_HI: begin
        if (xfer) begin
          // Opcode byte must have its top bit clear; abort before any write.
          if (in_data[BYTE_W-1]) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            hi_d    = in_data[OPCODE_W-1:0];
`ifdef IM_LOADER_CHECKSUM_EN
            xsum_d  = xsum_q ^ in_data;
`endif
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (xfer) begin
          im_wdata_d   = {hi_q, in_data};
          im_we_d      = 1'b1;
          words_left_d = words_left_q - 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          xsum_d       = xsum_q ^ in_data;
`endif
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // im_we is high during this cycle at the current address.
        addr_d = addr_q + 1'b1;
        if (words_left_q == '0) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_HI;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (in_data == xsum_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_FINISH: begin
        state_d    = ST_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
        error_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset restores the idle, CPU-held condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_COUNT;
      addr_q       <= '0;
      words_left_q <= '0;
      hi_q         <= '0;
      im_we_q      <= 1'b0;
      im_wdata_q   <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      xsum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      hi_q         <= hi_d;
      im_we_q      <= im_we_d;
      im_wdata_q   <= im_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IM_LOADER_CHECKSUM_EN
      xsum_q       <= xsum_d;
`endif
    end
  end

  assign im_we     = im_we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = im_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: frame driver, IM-write scoreboard, scenario tasks.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int W      = ADDR_W + INSTR_W;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [7:0]          in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                im_we;
  logic [ADDR_W-1:0]   im_addr;
  logic [INSTR_W-1:0]  im_wdata;
  logic                cpu_hold;
  logic                done;
  logic                error;
  state_e              dbg_state;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  logic [W-1:0]        exp_q[$];
  logic [INSTR_W-1:0]  wbuf[0:7];

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every IM write must match the oldest expected {addr, data}
  always @(negedge clk) begin : monitor
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (!reset && im_we === 1'b1) begin
      we_count++;
      checks++;
      got = {im_addr, im_wdata};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL im_write got=%h required=%h", got, want);
        end
      end
    end
  end

  // Driver: present one byte (after an optional idle gap), hold until accepted.
  // Entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int t;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    for (int i = 0; i < g; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      failures++;
      $display("FAIL send_timeout got=in_ready_low required=accept byte=%h", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: send N and the first nsend words of wbuf; checksum appended when the frame is complete.
  task automatic send_frame(input int n, input int nsend, input int gap);
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    cs = 8'(n);
    send_byte(8'(n), gap);
    for (int i = 0; i < nsend; i++) begin
      hi = {1'b0, wbuf[i][14:8]};
      lo = wbuf[i][7:0];
      cs = cs ^ hi ^ lo;
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send_byte(hi, gap);
      send_byte(lo, gap);
      checks++;
      if (im_we !== 1'b1 || im_addr !== ADDR_W'(i)) begin
        failures++;
        $display("FAIL write_latency word=%0d got=we%b/addr%h required=we1/addr%h", i, im_we, im_addr, ADDR_W'(i));
      end
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (nsend == n) send_byte(cs, gap);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 60) begin
      failures++;
      $display("FAIL end_timeout got=done%b/error%b required=terminal", done, error);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({im_we, im_addr, im_wdata, cpu_hold, done, error, in_ready} !==
        {1'b0, {ADDR_W{1'b0}}, {INSTR_W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s got=we%b addr%h data%h hold%b done%b err%b rdy%b required=we0 addr00 data0000 hold1 done0 err0 rdy0",
               name, im_we, im_addr, im_wdata, cpu_hold, done, error, in_ready);
    end
  endtask

  task automatic check_success(input string name, input int writes);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_status got=done%b err%b hold%b rdy%b required=done1 err0 hold0 rdy0", name, done, error, cpu_hold, in_ready);
    end
    checks++;
    if (writes !== 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes got=missing%0d pending%0d required=0/0", name, writes, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset_hold");
    checks++;
    if (dbg_state !== ST_COUNT) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d", dbg_state, ST_COUNT);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release got=%b required=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_two_words();
    int w0;
    w0 = we_count;
    wbuf[0] = 15'h0105;
    wbuf[1] = 15'h40FF;
    send_frame(2, 2, 0);
    wait_end();
    check_success("two_words", 2 - (we_count - w0));
  endtask

  task automatic test_zero_words();
    int w0;
    do_reset();
    w0 = we_count;
    send_frame(0, 0, 0);
`ifndef IM_LOADER_CHECKSUM_EN
    checks++;
    if (done !== 1'b0 || dbg_state !== ST_FINISH) begin
      failures++;
      $display("FAIL zero_finish_cycle got=done%b state%0d required=done0 state%0d", done, dbg_state, ST_FINISH);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done_latency got=%b required=1", done);
    end
`endif
    wait_end();
    check_success("zero_words", we_count - w0);
  endtask

  task automatic test_bad_hi();
    int w0;
    do_reset();
    w0 = we_count;
    send_byte(8'h01, 0);
    send_byte(8'h80, 0);
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bad_hi_status got=err%b done%b hold%b rdy%b required=err1 done0 hold1 rdy0", error, done, cpu_hold, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (we_count != w0 || error !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL bad_hi_no_write got=writes%0d err%b hold%b required=writes0 err1 hold1", we_count - w0, error, cpu_hold);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    do_reset();
    w0 = we_count;
    for (int i = 0; i < 5; i++) wbuf[i] = 15'($urandom);
    send_frame(5, 5, 3);
    wait_end();
    check_success("backpressure", 5 - (we_count - w0));
    // Bytes offered after DONE are never taken
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b1) begin
        failures++;
        $display("FAIL after_done got=rdy%b done%b required=rdy0 done1", in_ready, done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int w0;
    do_reset();
    w0 = we_count;
    for (int i = 0; i < 5; i++) wbuf[i] = 15'($urandom);
    send_frame(5, 3, 1);
    @(negedge clk);
    checks++;
    if (we_count - w0 != 3) begin
      failures++;
      $display("FAIL mid_load_writes got=%0d required=3", we_count - w0);
    end
    reset = 1'b1;
    #1;
    check_reset_values("mid_load_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== ST_COUNT) begin
      failures++;
      $display("FAIL mid_load_release got=rdy%b state%0d required=rdy1 state%0d", in_ready, dbg_state, ST_COUNT);
    end
    @(negedge clk);
    w0 = we_count;
    wbuf[0] = 15'h7ABC;
    wbuf[1] = 15'h0011;
    send_frame(2, 2, 0);
    wait_end();
    check_success("reload", 2 - (we_count - w0));
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    exp_q.push_back({ADDR_W'(0), 15'h1234});
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h27, 0);
    in_valid = 1'b0;
    wait_end();
    check_success("checksum_ok", exp_q.size());
    do_reset();
    exp_q.push_back({ADDR_W'(0), 15'h1234});
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h00, 0);
    in_valid = 1'b0;
    wait_end();
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL checksum_bad got=err%b done%b hold%b pending%0d required=err1 done0 hold1 pending0",
               error, done, cpu_hold, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_words();
    test_bad_hi();
    test_backpressure();
    test_reset_mid_load();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
